// File: rtl/led_ctl_pkg.sv
// led_ctl_pkg: display mode constants and mode type shared by the LED controller
package led_ctl_pkg;
  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_SWAP   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_SCAN   = 2'd3
  } mode_t;
endpackage

// File: rtl/led_pattern_ctl_if.sv
// led_pattern_ctl_if: received-character bus from the UART receiver
interface led_pattern_ctl_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rx_data;
  logic              rx_data_rdy;
  modport master (output rx_data, output rx_data_rdy);
  modport slave  (input rx_data, input rx_data_rdy);
endinterface

// File: rtl/rise_edge_det.sv
// rise_edge_det: one-cycle pulse on a low-to-high transition of a synchronous level
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic p_o
);
  logic prev_q;
  // remember last cycle's level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= d_i;
  assign p_o = d_i & ~prev_q;
endmodule

// File: rtl/led_pattern_ctl.sv
// led_pattern_ctl: character history capture and mode-selectable LED pattern driver
module led_pattern_ctl
  import led_ctl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int BLINK_CYC = 25_000_000
) (
  input  logic                         clk_rx,
  input  logic                         rst_n_clk_rx,
  input  logic                         btn_clk_rx,
  led_pattern_ctl_if.slave             rx_if,
  output logic [DATA_W-1:0]            led_o,
  output logic [1:0]                   mode_o,
  output logic [$clog2(DEPTH+1)-1:0]   hist_cnt_o
);
  localparam int TW = $clog2(BLINK_CYC);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int H  = DATA_W/2;
  logic              cap, step, tick;
  mode_t             mode_q, mode_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              phase_q, phase_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     hcnt_q, hcnt_d, idx_nx;
  logic [DATA_W-1:0] hist_q [DEPTH];
  logic [DATA_W-1:0] hist_d [DEPTH];
  logic [DATA_W-1:0] led_q, led_d;
  rise_edge_det u_rdy_edge (.clk(clk_rx), .rst_n(rst_n_clk_rx), .d_i(rx_if.rx_data_rdy), .p_o(cap));
  rise_edge_det u_btn_edge (.clk(clk_rx), .rst_n(rst_n_clk_rx), .d_i(btn_clk_rx), .p_o(step));
  // next state: mode stepping restarts the tick/blink/scan timing; LEDs derive from current state
  always_comb begin
    tick    = tcnt_q == TW'(BLINK_CYC-1);
    idx_nx  = CW'(idx_q) + CW'(1);
    mode_d  = step ? mode_t'(mode_q + 2'd1) : mode_q;
    tcnt_d  = (step || tick) ? '0 : tcnt_q + TW'(1);
    phase_d = step ? 1'b1 : (tick ? ~phase_q : phase_q);
    idx_d   = step ? '0 : ((tick && mode_q == MODE_SCAN) ? ((idx_nx >= hcnt_q) ? '0 : IW'(idx_nx)) : idx_q);
    hcnt_d  = (cap && hcnt_q != CW'(DEPTH)) ? hcnt_q + CW'(1) : hcnt_q;
    hist_d[0] = cap ? rx_if.rx_data : hist_q[0];
    for (int i = 1; i < DEPTH; i++) hist_d[i] = cap ? hist_q[i-1] : hist_q[i];
    led_d = (mode_q == MODE_DIRECT) ? hist_q[0] :
            (mode_q == MODE_SWAP)   ? {hist_q[0][H-1:0], hist_q[0][DATA_W-1:H]} :
            (mode_q == MODE_BLINK)  ? (phase_q ? hist_q[0] : '0) :
            (hcnt_q == '0)          ? '0 : hist_q[idx_q];
  end
  // state registers, cleared immediately on reset
  always_ff @(posedge clk_rx or negedge rst_n_clk_rx)
    if (!rst_n_clk_rx) begin
      mode_q  <= MODE_DIRECT;
      tcnt_q  <= '0;
      phase_q <= 1'b1;
      idx_q   <= '0;
      hcnt_q  <= '0;
      led_q   <= '0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      mode_q  <= mode_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      hcnt_q  <= hcnt_d;
      led_q   <= led_d;
      hist_q  <= hist_d;
    end
  assign led_o      = led_q;
  assign mode_o     = mode_q;
  assign hist_cnt_o = hcnt_q;
endmodule

// File: tb/tb_led_pattern_ctl.sv
// tb_led_pattern_ctl: directed self-checking bench for led_pattern_ctl
module tb_led_pattern_ctl;
  logic       clk_rx = 1'b0;
  logic       rst_n_clk_rx = 1'b0;
  logic       btn_clk_rx = 1'b0;
  logic [7:0] led_o;
  logic [1:0] mode_o;
  logic [2:0] hist_cnt_o;
  int total = 0;
  int bad = 0;
  led_pattern_ctl_if #(.DATA_W(8)) rx_if ();
  led_pattern_ctl #(.DATA_W(8), .DEPTH(4), .BLINK_CYC(4)) dut (
    .clk_rx(clk_rx), .rst_n_clk_rx(rst_n_clk_rx), .btn_clk_rx(btn_clk_rx),
    .rx_if(rx_if), .led_o(led_o), .mode_o(mode_o), .hist_cnt_o(hist_cnt_o)
  );
  always #5 clk_rx = ~clk_rx;
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk_rx);
    #1;
  endtask
  task automatic pulse_btn();
    btn_clk_rx = 1'b1;
    tick();
    btn_clk_rx = 1'b0;
    tick();
  endtask
  task automatic send(input logic [7:0] c);
    rx_if.rx_data = c;
    rx_if.rx_data_rdy = 1'b1;
    tick();
    rx_if.rx_data_rdy = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    rx_if.rx_data = 8'h00;
    rx_if.rx_data_rdy = 1'b0;
    rst_n_clk_rx = 1'b0;
    tick();
    tick();
    rst_n_clk_rx = 1'b1;
    tick();
    total++; if (led_o !== 8'h00) begin bad++; $display("FAIL reset_led got=%h exp=00", led_o); end
    total++; if (mode_o !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d exp=0", mode_o); end
    total++; if (hist_cnt_o !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", hist_cnt_o); end
  endtask
  task automatic test_capture();
    rx_if.rx_data = 8'hA5;
    rx_if.rx_data_rdy = 1'b1;
    tick();
    total++; if (hist_cnt_o !== 3'd1) begin bad++; $display("FAIL cap_cnt got=%0d exp=1", hist_cnt_o); end
    total++; if (led_o !== 8'h00) begin bad++; $display("FAIL cap_led_early got=%h exp=00", led_o); end
    tick();
    total++; if (led_o !== 8'hA5) begin bad++; $display("FAIL cap_led got=%h exp=a5", led_o); end
    tick();
    rx_if.rx_data_rdy = 1'b0;
    tick();
    total++; if (hist_cnt_o !== 3'd1) begin bad++; $display("FAIL cap_held_once got=%0d exp=1", hist_cnt_o); end
  endtask
  task automatic test_mode();
    btn_clk_rx = 1'b1;
    tick();
    total++; if (mode_o !== 2'd1) begin bad++; $display("FAIL mode_step got=%0d exp=1", mode_o); end
    btn_clk_rx = 1'b0;
    tick();
    total++; if (led_o !== 8'h5A) begin bad++; $display("FAIL swap_led got=%h exp=5a", led_o); end
    pulse_btn();
    total++; if (mode_o !== 2'd2) begin bad++; $display("FAIL mode_two got=%0d exp=2", mode_o); end
    pulse_btn();
    pulse_btn();
    total++; if (mode_o !== 2'd0) begin bad++; $display("FAIL mode_wrap got=%0d exp=0", mode_o); end
    total++; if (led_o !== 8'hA5) begin bad++; $display("FAIL direct_led got=%h exp=a5", led_o); end
  endtask
  task automatic test_blink();
    pulse_btn();
    btn_clk_rx = 1'b1;
    tick();
    btn_clk_rx = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] exp;
      tick();
      exp = ((i / 4) % 2 == 0) ? 8'hA5 : 8'h00;
      total++; if (led_o !== exp) begin bad++; $display("FAIL blink[%0d] got=%h exp=%h", i, led_o, exp); end
    end
  endtask
  task automatic test_scan();
    logic [7:0] seq [4];
    seq[0] = 8'h55; seq[1] = 8'h44; seq[2] = 8'h33; seq[3] = 8'h22;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    total++; if (hist_cnt_o !== 3'd4) begin bad++; $display("FAIL scan_cnt got=%0d exp=4", hist_cnt_o); end
    btn_clk_rx = 1'b1;
    tick();
    btn_clk_rx = 1'b0;
    total++; if (mode_o !== 2'd3) begin bad++; $display("FAIL scan_mode got=%0d exp=3", mode_o); end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (led_o !== seq[(i / 4) % 4]) begin bad++; $display("FAIL scan[%0d] got=%h exp=%h", i, led_o, seq[(i / 4) % 4]); end
    end
  endtask
  task automatic test_async_reset();
    tick();
    #2;
    rst_n_clk_rx = 1'b0;
    #1;
    total++; if (led_o !== 8'h00) begin bad++; $display("FAIL arst_led got=%h exp=00", led_o); end
    total++; if (mode_o !== 2'd0) begin bad++; $display("FAIL arst_mode got=%0d exp=0", mode_o); end
    total++; if (hist_cnt_o !== 3'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", hist_cnt_o); end
    tick();
    rst_n_clk_rx = 1'b1;
    tick();
  endtask
  task automatic test_scan_empty();
    pulse_btn(); pulse_btn(); pulse_btn();
    total++; if (mode_o !== 2'd3) begin bad++; $display("FAIL empty_mode got=%0d exp=3", mode_o); end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (led_o !== 8'h00) begin bad++; $display("FAIL empty_scan[%0d] got=%h exp=00", i, led_o); end
    end
    pulse_btn();
    total++; if (mode_o !== 2'd0) begin bad++; $display("FAIL empty_wrap got=%0d exp=0", mode_o); end
  endtask
  task automatic test_simultaneous();
    rx_if.rx_data = 8'h3C;
    rx_if.rx_data_rdy = 1'b1;
    btn_clk_rx = 1'b1;
    tick();
    total++; if (mode_o !== 2'd1) begin bad++; $display("FAIL simul_mode got=%0d exp=1", mode_o); end
    total++; if (hist_cnt_o !== 3'd1) begin bad++; $display("FAIL simul_cnt got=%0d exp=1", hist_cnt_o); end
    rx_if.rx_data_rdy = 1'b0;
    btn_clk_rx = 1'b0;
    tick();
    total++; if (led_o !== 8'hC3) begin bad++; $display("FAIL simul_led got=%h exp=c3", led_o); end
  endtask
  initial begin
    test_reset();
    test_capture();
    test_mode();
    test_blink();
    test_scan();
    test_async_reset();
    test_scan_empty();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_pattern_ctl.md
# led_pattern_ctl

Parametrised LED output generator for the UART receive path; successor to the single-byte LED controller. Captures each received character into a DEPTH-entry history, and drives the LEDs in one of four display modes (direct, nibble-swap, blink, history scan), selected by stepping through the modes with a button. Sits between the UART receiver and the board LED pins, fully in the clk_rx domain.

## Interface

- DATA_W, 8, character and LED width; even, ≥ 2
- DEPTH, 4, history entries; ≥ 2
- BLINK_CYC, 25_000_000, clk_rx cycles per blink/scan tick; ≥ 2
- clk_rx  input  1  receive-domain clock
- rst_n_clk_rx  input  1  reset, asynchronous, active-low; deassertion synchronous to clk_rx
- btn_clk_rx  input  1  mode-step button, already debounced and synchronised to clk_rx
- rx_data  input  DATA_W  received character, valid while rx_data_rdy is high
- rx_data_rdy  input  1  ready strobe for rx_data (level; its rising edge marks a new character)
- led_o  output  DATA_W  registered LED outputs
- mode_o  output  2  current display mode
- hist_cnt_o  output  $clog2(DEPTH+1)  number of valid history entries, saturating at DEPTH

## Operation

- Reset (async): led_o=0, mode_o=0, hist_cnt_o=0, all hist[]=0, tick counter=0, blink phase=1, scan index=0, both edge-detect registers=0.
- Character capture: on the rising edge of rx_data_rdy (high now, low last cycle), shift the history so hist[i] <= hist[i-1] and hist[0] <= rx_data. The oldest entry is dropped. hist_cnt_o increments and saturates at DEPTH. A level held high captures once.
- Mode step: on the rising edge of btn_clk_rx, mode_o <= mode_o+1, wrapping 3→0. A mode change also clears the tick counter and scan index, and sets blink phase=1.
- Tick: the counter runs 0..BLINK_CYC-1 and wraps. A tick pulse fires on the cycle the counter equals BLINK_CYC-1. On a tick, blink phase toggles. In SCAN mode, a tick also advances the scan index: idx <= (idx+1 ≥ hist_cnt_o) ? 0 : idx+1.
- Display modes (led_o registered):
  - 0 DIRECT: hist[0]
  - 1 SWAP: {hist[0][DATA_W/2-1:0], hist[0][DATA_W-1:DATA_W/2]}
  - 2 BLINK: phase ? hist[0] : 0
  - 3 SCAN: hist_cnt_o==0 ? 0 : hist[idx]; hist[0] is the newest entry.
- Simultaneous character capture and mode step in the same cycle: both take effect in that cycle.
- A new character in SCAN mode does not reset idx. idx is always below hist_cnt_o, because the count never decreases except on reset.
- Reset asserted mid-operation: all state returns immediately to its reset value. History contents are lost.

## Timing

- rx_data_rdy rising edge sampled at clock edge k: hist[0] updates at k, and led_o shows the new character at k+1.
- btn_clk_rx rising edge sampled at edge k: mode_o updates at k, and led_o reflects the new mode at k+1.
- Blink period is 2·BLINK_CYC cycles, 50% duty. The first phase after a mode change lasts BLINK_CYC cycles with LEDs on.
- SCAN dwell is BLINK_CYC cycles per entry.
- No combinational path from any input to any output.

## Structure

- Shared package led_ctl_pkg holds the mode constants MODE_DIRECT=2'd0, MODE_SWAP=2'd1, MODE_BLINK=2'd2, MODE_SCAN=2'd3, and the mode type.
- Sub-module rise_edge_det (clk, async active-low reset, level in, one-cycle pulse out) is instantiated twice, once for rx_data_rdy and once for btn_clk_rx.
- Tick counter width is $clog2(BLINK_CYC). Scan index width is $clog2(DEPTH).

## Test plan

- Reset, then send 0xA5 (rx_data_rdy high for 3 cycles), DATA_W=8 → hist_cnt_o=1, and led_o=0xA5 one cycle after the capture edge; the held level produces no second capture.
- One button pulse with 0xA5 held → mode_o=1, led_o=0x5A; four pulses in total → mode_o wraps to 0.
- Mode BLINK, BLINK_CYC=4 → led_o=0xA5 for 4 cycles, 0x00 for 4, repeating.
- Mode SCAN, DEPTH=4, send 0x11,0x22,0x33,0x44,0x55 → hist_cnt_o=4, and led_o cycles 0x55,0x44,0x33,0x22 every BLINK_CYC cycles, then wraps.
- SCAN with hist_cnt_o=0 → led_o=0. Character capture and button pulse in the same cycle → both registered, and led_o uses the new mode with the new data.
- Assert rst_n_clk_rx low mid-scan, asynchronously between clock edges → all outputs are 0 before the next clk_rx edge.
